// File: rtl/ship_pkg.sv
// ship_pkg: shared types and default constants for the spaceship position
// controller (FSM state encoding, motion tuning defaults, step width).
package ship_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } ship_state_t;

    localparam int DEADZONE   = 64;
    localparam int STEP_SHIFT = 6;
    localparam int MAX_STEP   = 8;
    localparam int X_INIT     = 300;
    localparam int Y_INIT     = 240;

    // Wide enough to hold MAX_STEP.
    localparam int STEP_W     = 4;

endpackage

// File: rtl/axis_step.sv
// axis_step: converts one signed tilt sample into a per-frame step.
//   a_i    : signed 16-bit tilt sample
//   step_o : step magnitude in pixels (0 inside the dead zone, capped at MAX_STEP)
//   neg_o  : sign of the tilt (1 = negative)
// Purely combinational: abs -> dead zone -> shift -> saturate.
module axis_step
    import ship_pkg::*;
#(
    parameter int DEADZONE_P   = DEADZONE,
    parameter int STEP_SHIFT_P = STEP_SHIFT,
    parameter int MAX_STEP_P   = MAX_STEP
) (
    input  logic signed [15:0]       a_i,
    output logic        [STEP_W-1:0] step_o,
    output logic                     neg_o
);

    // -32768 has no positive counterpart; pin it to the largest magnitude.
    function automatic logic [15:0] abs_sat(input logic signed [15:0] a);
        if (a == 16'sh8000) begin
            return 16'h7fff;
        end else if (a < 0) begin
            return $unsigned(-a);
        end else begin
            return $unsigned(a);
        end
    endfunction

    function automatic logic [STEP_W-1:0] sat_step(input logic [15:0] raw);
        if (raw > 16'(MAX_STEP_P)) begin
            return STEP_W'(MAX_STEP_P);
        end else begin
            return raw[STEP_W-1:0];
        end
    endfunction

    logic [15:0] mag;

    always_comb begin
        mag    = abs_sat(a_i);
        step_o = '0;
        if (mag >= 16'(DEADZONE_P)) begin
            step_o = sat_step(((mag - 16'(DEADZONE_P)) >> STEP_SHIFT_P) + 16'd1);
        end
        neg_o  = a_i[15];
    end

endmodule

// File: rtl/ship_position_ctrl.sv
// ship_position_ctrl: updates the spaceship sprite position once per frame
// from latched accelerometer tilt.
//   clk_pix      : pixel clock
//   rst          : synchronous active-high reset
//   frame        : start-of-frame pulse; starts one update when idle
//   sample_valid : strobe qualifying accel_x / accel_y
//   accel_x/y    : signed tilt (+x moves right, +y moves up)
//   freeze       : hold position during the commit
//   ship_x/y     : sprite top-left corner
//   moving       : last commit changed the position
//   at_edge      : {bottom, top, right, left} limit flags of committed position
module ship_position_ctrl
    import ship_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int SCREEN_CORDW = 16,
    parameter int SPRITE_W     = 34,
    parameter int SPRITE_H     = 36,
    parameter int X_INIT_P     = X_INIT,
    parameter int Y_INIT_P     = Y_INIT,
    parameter int DEADZONE_P   = DEADZONE,
    parameter int STEP_SHIFT_P = STEP_SHIFT,
    parameter int MAX_STEP_P   = MAX_STEP
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    sample_valid,
    input  logic signed [15:0]      accel_x,
    input  logic signed [15:0]      accel_y,
    input  logic                    freeze,
    output logic [SCREEN_CORDW-1:0] ship_x,
    output logic [SCREEN_CORDW-1:0] ship_y,
    output logic                    moving,
    output logic [3:0]              at_edge
);

    localparam int CW = SCREEN_CORDW;
    localparam logic [CW-1:0] X_MAX = CW'(H_RES - SPRITE_W);
    localparam logic [CW-1:0] Y_MAX = CW'(V_RES - SPRITE_H);

    // Two guard bits so over/underflow is visible before clamping.
    function automatic logic [CW-1:0] clamp(input logic signed [CW+1:0] v,
                                            input logic [CW-1:0] hi);
        if (v < 0) begin
            return '0;
        end else if (v > $signed({2'b00, hi})) begin
            return hi;
        end else begin
            return v[CW-1:0];
        end
    endfunction

    ship_state_t state_q, state_d;

    logic signed [15:0] lat_x_q, lat_y_q;
    logic signed [15:0] wrk_x_q, wrk_y_q;
    logic [CW-1:0]      nx_q, ny_q;
    logic [CW-1:0]      ship_x_q, ship_y_q;
    logic               moving_q;
    logic [3:0]         at_edge_q;

    logic signed [15:0]       axis_in;
    logic [STEP_W-1:0]        step;
    logic                     step_neg;
    logic signed [CW+1:0]     delta;
    logic signed [CW+1:0]     cand_x, cand_y;
    logic [CW-1:0]            fin_x, fin_y;

    // One step unit shared by both axes.
    assign axis_in = (state_q == CALC_Y) ? wrk_y_q : wrk_x_q;

    axis_step #(
        .DEADZONE_P  (DEADZONE_P),
        .STEP_SHIFT_P(STEP_SHIFT_P),
        .MAX_STEP_P  (MAX_STEP_P)
    ) u_axis_step (
        .a_i   (axis_in),
        .step_o(step),
        .neg_o (step_neg)
    );

    always_comb begin
        delta  = $signed({{(CW+2-STEP_W){1'b0}}, step});
        if (step_neg) begin
            delta = -delta;
        end
        cand_x = $signed({2'b00, ship_x_q}) + delta;
        // Screen y grows downwards, so positive tilt subtracts.
        cand_y = $signed({2'b00, ship_y_q}) - delta;
        fin_x  = freeze ? ship_x_q : nx_q;
        fin_y  = freeze ? ship_y_q : ny_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame) state_d = CALC_X;
            CALC_X:  state_d = CALC_Y;
            CALC_Y:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_x_q   <= '0;
            lat_y_q   <= '0;
            ship_x_q  <= CW'(X_INIT_P);
            ship_y_q  <= CW'(Y_INIT_P);
            moving_q  <= 1'b0;
            at_edge_q <= '0;
        end else begin
            state_q <= state_d;
            if (sample_valid) begin
                lat_x_q <= accel_x;
                lat_y_q <= accel_y;
            end
            if (state_q == COMMIT) begin
                ship_x_q  <= fin_x;
                ship_y_q  <= fin_y;
                moving_q  <= (fin_x != ship_x_q) || (fin_y != ship_y_q);
                at_edge_q <= {fin_y == Y_MAX, fin_y == '0, fin_x == X_MAX, fin_x == '0};
            end
        end
    end

    // Working registers: snapshot taken from the previous latch contents, so a
    // sample arriving with the frame pulse serves the following frame.
    always_ff @(posedge clk_pix) begin
        if (state_q == IDLE && frame) begin
            wrk_x_q <= lat_x_q;
            wrk_y_q <= lat_y_q;
        end
        if (state_q == CALC_X) nx_q <= clamp(cand_x, X_MAX);
        if (state_q == CALC_Y) ny_q <= clamp(cand_y, Y_MAX);
    end

    assign ship_x  = ship_x_q;
    assign ship_y  = ship_y_q;
    assign moving  = moving_q;
    assign at_edge = at_edge_q;

endmodule

// File: doc/ship_position_ctrl.md
# ship_position_ctrl

This block produces the spaceship sprite's screen position from accelerometer tilt samples. It sits between the accelerometer SPI front end and the spaceship `sprite` instance, and runs entirely in the `clk_pix` domain. The position updates once per video frame, so the sprite never tears mid-frame. Motion uses a tilt dead zone, proportional speed with saturation, and clamping to the visible screen.

## Interface
- `H_RES`, 640, visible width in pixels
- `V_RES`, 480, visible height in pixels
- `SCREEN_CORDW`, 16, coordinate width in bits
- `SPRITE_W`, 34, scaled sprite width in pixels (17×2)
- `SPRITE_H`, 36, scaled sprite height in pixels (18×2)
- `X_INIT`, 300, reset x position
- `Y_INIT`, 240, reset y position
- `DEADZONE`, 64, magnitude below which an axis produces no motion
- `STEP_SHIFT`, 6, right-shift applied to excess tilt
- `MAX_STEP`, 8, maximum pixels moved per frame per axis
- Clocking and reset (already decided): one clock, `clk_pix`; `rst` is synchronous and active-high.
- `clk_pix` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `frame` in 1: one-cycle pulse at the start of each frame.
- `sample_valid` in 1: one-cycle strobe; the accel sample is valid this cycle (already synchronised to `clk_pix`).
- `accel_x` in 16: signed two's-complement tilt; positive moves right.
- `accel_y` in 16: signed two's-complement tilt; positive moves up.
- `freeze` in 1: hold position while high.
- `ship_x` out SCREEN_CORDW: sprite left edge.
- `ship_y` out SCREEN_CORDW: sprite top edge.
- `moving` out 1: the last commit changed the position.
- `at_edge` out 4: {bottom, top, right, left}; the committed position is on that limit.

## Operation
- **Sample latch:** on `sample_valid`, capture `accel_x`/`accel_y` into `lat_x`/`lat_y`. Reset value is 0, so there is no motion until the first sample arrives.
- **FSM states:** IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE → CALC_X on `frame`.
  - CALC_X → CALC_Y → COMMIT → IDLE unconditionally.
  - `frame` outside IDLE is ignored.
- **Step computation per axis:**
  - mag = |a|, with −32768 saturated to 32767.
  - If mag < DEADZONE, step = 0.
  - Otherwise step = min(MAX_STEP, ((mag − DEADZONE) >> STEP_SHIFT) + 1).
- **Position update:**
  - x' = x + sign·step, clamped to [0, H_RES − SPRITE_W].
  - y' = y − sign·step (positive tilt moves up), clamped to [0, V_RES − SPRITE_H].
  - Arithmetic is signed, SCREEN_CORDW+2 bits wide, so no wrap occurs before the clamp.
- **COMMIT:**
  - Writes `ship_x`, `ship_y`, `moving` and `at_edge` together.
  - If `freeze` is high in COMMIT, positions hold and `moving` = 0; sampling continues.
- **Simultaneous events:**
  - `sample_valid` and `frame` in the same cycle: the frame uses the previously latched sample; the new sample serves the next frame.
  - `rst` overrides everything, including mid-FSM: state → IDLE, positions → init, latch → 0.
- **Reset values:** `ship_x` = X_INIT, `ship_y` = Y_INIT, `moving` = 0, `at_edge` = 0.

## Timing
- `frame` sampled at edge N:
  - state = CALC_X after N
  - CALC_Y after N+1
  - COMMIT after N+2
  - outputs update at edge N+3, and state returns to IDLE
- Latency from `frame` to output is 3 edges, which falls well inside blanking.
- All outputs are registered and stable between commits.
- One commit per frame at most.
- `sample_valid` can be accepted on any cycle, including while the FSM is busy. The values used in CALC_X/CALC_Y are snapshotted into working registers at the `frame` edge.

## Structure
- `ship_pkg` holds:
  - the `ship_state_t` enum (IDLE, CALC_X, CALC_Y, COMMIT)
  - default constants (DEADZONE, STEP_SHIFT, MAX_STEP, X_INIT, Y_INIT)
- Sub-module `axis_step`:
  - combinational abs → deadzone → shift → saturate
  - signed 16-bit in; step magnitude plus sign out
  - one instance, time-shared between CALC_X and CALC_Y through a mux on the FSM state

## Test plan
- Hold `rst` for 2 cycles → `ship_x` = 300, `ship_y` = 240, `moving` = 0, `at_edge` = 0; assert `rst` during CALC_Y → same values and state IDLE next cycle.
- Sample `accel_x` = +200, then `frame` → `ship_x` = 303 exactly 3 edges after `frame` (step 3), `ship_y` unchanged, `moving` = 1.
- `accel_x` = 40, `accel_y` = −63 (inside dead zone), then `frame` → position unchanged, `moving` = 0.
- Start from x = 5 with `accel_x` = −32768 and send 2 frames → x = 0 after the first frame (step 8, clamped), `at_edge[0]` = 1; x stays 0 on the second frame.
- `accel_y` = +1000 → y 240 → 232 (step capped at 8); from y = 440, `accel_y` = −1000 → y = 444, `at_edge[3]` = 1.
- `sample_valid` (`accel_x` = +200) in the same cycle as `frame`, with the old latch = 0 → no move this frame, +3 on the next; `freeze` = 1 during COMMIT → position held, `moving` = 0.
